aes_cipher_core: RTL and testbench

AES_CIPHER_CORE -- requirements
Module: aes_cipher_core

---
 rtl/aes_cipher_core.sv | 150 +++++++++++++++
 tb/tb_aes_cipher_core.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
// AES forward cipher, one round per clock. The caller supplies the expanded
// key schedule and holds it stable for the whole encryption.
module aes_cipher_core #(
    parameter int unsigned nk = 4,
    parameter int unsigned nr = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [0:127]                 data_in,
    input  logic [0:((nr+1)*128)-1]      keys,
    output logic [0:127]                 data_out,
    output logic                         busy,
    output logic                         done
);

    // Key length and round count must describe the same AES variant.
    if (nr != nk + 6) begin : g_cfg_check
        $error("aes_cipher_core: nr must equal nk + 6");
    end

    localparam logic [3:0] last_round = 4'(nr);

    // FIPS-197 forward S-box, entry x at bits [8*x +: 8].
    localparam logic [0:2047] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         fsm;
    logic [3:0]   round;
    logic [0:127] state;
    logic [0:127] sub;
    logic [0:127] shifted;
    logic [0:127] mixed;
    logic [0:127] rk;
    logic [0:127] round_out;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return sbox_tab[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:31] mix_col(input logic [0:31] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[0:7];
        a1 = c[8:15];
        a2 = c[16:23];
        a3 = c[24:31];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // SubBytes: 16 parallel S-box lookups.
    always_comb begin
        sub = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            sub[i*8 +: 8] = sbox(state[i*8 +: 8]);
        end
    end

    // ShiftRows: byte (row, col) takes the byte from (row, col + row).
    always_comb begin
        shifted = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                shifted[(c*4 + r)*8 +: 8] = sub[(((c + r) % 4)*4 + r)*8 +: 8];
            end
        end
    end

    // MixColumns on each of the four columns.
    always_comb begin
        mixed = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            mixed[c*32 +: 32] = mix_col(shifted[c*32 +: 32]);
        end
    end

    // Round-key select by the round counter.
    always_comb begin
        rk = '0;
        for (int unsigned r = 0; r <= nr; r++) begin
            if (round == 4'(r)) rk = keys[r*128 +: 128];
        end
    end

    // Final round skips MixColumns.
    always_comb begin
        round_out = ((round == last_round) ? shifted : mixed) ^ rk;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= IDLE;
            round    <= '0;
            state    <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        state <= data_in ^ keys[0 +: 128];
                        round <= 4'd1;
                        busy  <= 1'b1;
                        fsm   <= RUN;
                    end
                end
                RUN: begin
                    state <= round_out;
                    if (round == last_round) begin
                        data_out <= round_out;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        fsm      <= IDLE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: AES-128/192/256 instances, known-answer table,
// timing corner sequences and randomized runs against a byte-level model.
module tb_aes_cipher_core;

    typedef logic [7:0] byte_t;

    typedef struct {
        int unsigned  k;     // 0: nk=4, 1: nk=6, 2: nk=8
        logic [0:255] key;   // left-justified cipher key
        logic [0:127] pt;
        logic [0:127] ct;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [2:0]   st;
    logic [0:127] din;
    logic [0:1919] ksched;
    logic [0:127] dout [3];
    logic [2:0]   busy_v;
    logic [2:0]   done_v;

    int unsigned n_cmp;
    int unsigned n_bad;
    byte_t       sbox_m [256];

    aes_cipher_core #(.nk(4), .nr(10)) u_aes128 (
        .clk(clk), .rst(rst), .start(st[0]), .data_in(din),
        .keys(ksched[0 +: 1408]), .data_out(dout[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    aes_cipher_core #(.nk(6), .nr(12)) u_aes192 (
        .clk(clk), .rst(rst), .start(st[1]), .data_in(din),
        .keys(ksched[0 +: 1664]), .data_out(dout[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    aes_cipher_core #(.nk(8), .nr(14)) u_aes256 (
        .clk(clk), .rst(rst), .start(st[2]), .data_in(din),
        .keys(ksched[0 +: 1920]), .data_out(dout[2]),
        .busy(busy_v[2]), .done(done_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic byte_t gmul(input byte_t a_in, input byte_t b_in);
        byte_t a, b, p;
        logic  hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic byte_t rotl8(input byte_t v, input int n);
        return byte_t'((v << n) | (v >> (8 - n)));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic init_sbox();
        byte_t inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(byte_t'(x), byte_t'(y)) == 8'h01) inv = byte_t'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [0:1919] expand(input int unsigned nkk, input logic [0:255] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        byte_t         rc;
        logic [0:1919] ks;
        int unsigned   total;
        total = 4 * (nkk + 7);
        rc = 8'h01;
        ks = '0;
        for (int unsigned i = 0; i < 60; i++) w[i] = '0;
        for (int unsigned i = 0; i < nkk; i++) w[i] = key[i*32 +: 32];
        for (int unsigned i = nkk; i < total; i++) begin
            t = w[i-1];
            if (i % nkk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (nkk > 6 && i % nkk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nkk] ^ t;
        end
        for (int unsigned i = 0; i < total; i++) ks[i*32 +: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [0:127] cipher(input int unsigned nrr, input logic [0:127] pt,
                                            input logic [0:1919] ks);
        byte_t s [16];
        byte_t t [16];
        byte_t a [4];
        logic [0:127] res;
        for (int unsigned i = 0; i < 16; i++) s[i] = pt[i*8 +: 8] ^ ks[i*8 +: 8];
        for (int unsigned r = 1; r <= nrr; r++) begin
            for (int unsigned i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int unsigned c = 0; c < 4; c++)
                for (int unsigned row = 0; row < 4; row++)
                    s[c*4 + row] = t[((c + row) % 4)*4 + row];
            if (r < nrr) begin
                for (int unsigned c = 0; c < 4; c++) begin
                    for (int unsigned j = 0; j < 4; j++) a[j] = s[c*4 + j];
                    for (int unsigned j = 0; j < 4; j++)
                        s[c*4 + j] = gmul(a[j], 8'h02) ^ gmul(a[(j+1)%4], 8'h03)
                                     ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            end
            for (int unsigned i = 0; i < 16; i++) s[i] = s[i] ^ ks[r*128 + i*8 +: 8];
        end
        for (int unsigned i = 0; i < 16; i++) res[i*8 +: 8] = s[i];
        return res;
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a falling edge: present data and request a start.
    task automatic issue(input int unsigned k, input logic [0:127] pt);
        din = pt;
        st[k] = 1'b1;
    endtask

    // Runs edges until done; checks latency and result. Returns at the falling
    // edge inside the done cycle. poke_at > 0 pulses start mid-run.
    task automatic collect(input int unsigned k, input logic [0:127] exp,
                           input string name, input int unsigned poke_at);
        int unsigned n;
        bit          seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            st = '0;
            din = rnd128();
            if (n == poke_at) st[k] = 1'b1;
            if (done_v[k]) seen = 1'b1;
        end
        chk($sformatf("%s latency", name), 128'(n), 128'(k*2 + 11));
        chk($sformatf("%s data", name), dout[k], exp);
    endtask

    // Counts done/busy cycles for the given instance over a quiet window.
    task automatic quiet(input int unsigned k, input int unsigned cycles, input string name);
        int unsigned n_done, n_busy;
        n_done = 0;
        n_busy = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_v[k]) n_done++;
            if (busy_v[k]) n_busy++;
        end
        chk($sformatf("%s done pulses", name), 128'(n_done), 128'd0);
        chk($sformatf("%s busy cycles", name), 128'(n_busy), 128'd0);
    endtask

    // ---------------- test sequence ----------------
    vec_t          vecs [4];
    logic [0:255]  key_a, key_b;
    logic [0:127]  pt_a, pt_b, ct_a, ct_b;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        st = '0;
        din = '0;
        ksched = '0;
        rst = 1'b0;
        #1 rst = 1'b1;

        key_a = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        key_b = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        pt_a  = 128'h00112233445566778899aabbccddeeff;
        pt_b  = 128'h3243f6a8885a308d313198a2e0370734;
        ct_a  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;

        vecs[0] = '{k: 0, key: key_a, pt: pt_a, ct: ct_a};
        vecs[1] = '{k: 0, key: key_b, pt: pt_b, ct: ct_b};
        vecs[2] = '{k: 1, key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    pt: pt_a, ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        vecs[3] = '{k: 2, key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    pt: pt_a, ct: 128'h8ea2b7ca516745bfeafc49904b496089};

        init_sbox();

        // Reset state
        repeat (2) @(negedge clk);
        for (int unsigned k = 0; k < 3; k++) begin
            chk($sformatf("reset busy[%0d]", k), 128'(busy_v[k]), 128'd0);
            chk($sformatf("reset done[%0d]", k), 128'(done_v[k]), 128'd0);
            chk($sformatf("reset data_out[%0d]", k), dout[k], 128'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Known-answer table
        for (int unsigned v = 0; v < 4; v++) begin
            ksched = expand(4 + 2*vecs[v].k, vecs[v].key);
            issue(vecs[v].k, vecs[v].pt);
            collect(vecs[v].k, vecs[v].ct, $sformatf("kat%0d", v), 0);
            @(negedge clk);
            chk($sformatf("kat%0d done single", v), 128'(done_v[vecs[v].k]), 128'd0);
            chk($sformatf("kat%0d data held", v), dout[vecs[v].k], vecs[v].ct);
            chk($sformatf("kat%0d busy after", v), 128'(busy_v[vecs[v].k]), 128'd0);
        end

        // Back-to-back: start asserted in the done cycle
        ksched = expand(4, key_b);
        issue(0, pt_b);
        collect(0, ct_b, "b2b first", 0);
        ksched = expand(4, key_a);
        issue(0, pt_a);
        collect(0, ct_a, "b2b second", 0);
        @(negedge clk);
        chk("b2b done single", 128'(done_v[0]), 128'd0);

        // Start pulsed mid-run with other data is ignored
        issue(0, pt_a);
        collect(0, ct_a, "ignore start", 4);
        quiet(0, 15, "ignore start after");

        // Asynchronous reset mid-run (round 6), start held during reset
        ksched = expand(4, key_b);
        issue(0, pt_b);
        for (int unsigned i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            st = '0;
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst busy", 128'(busy_v[0]), 128'd0);
        chk("midrst done", 128'(done_v[0]), 128'd0);
        chk("midrst data_out", dout[0], 128'd0);
        st[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst start ignored busy", 128'(busy_v[0]), 128'd0);
        st = '0;
        rst = 1'b0;
        quiet(0, 15, "after rst");
        issue(0, pt_b);
        collect(0, ct_b, "after rst run", 0);
        @(negedge clk);

        // Randomized runs against the model
        for (int unsigned k = 0; k < 3; k++) begin
            for (int unsigned n = 0; n < ((k == 0) ? 8 : 3); n++) begin
                logic [0:255] rkey;
                logic [0:127] rpt;
                logic [0:127] exp;
                rkey = {rnd128(), rnd128()};
                rpt = rnd128();
                ksched = expand(4 + 2*k, rkey);
                exp = cipher(10 + 2*k, rpt, ksched);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(k, rpt);
                collect(k, exp, $sformatf("rand k%0d n%0d", k, n), 0);
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
